// File: rtl/lstm_cell_seq_if.sv
// lstm_cell_seq_if: stream/result bundle of one LSTM hidden unit.
//   slave  : seen by lstm_cell_seq (takes i_*, drives o_*)
//   master : seen by the layer sequencer / bench
// Signals:
//   i_start/i_first, i_b_{a,i,f,o}     timestep start, new-sequence flag, biases
//   i_valid/o_ready, i_d, i_w_{a,i,f,o} element stream (x first, then h) + weights
//   o_valid/i_ready                     result handshake
//   o_{a,i,f,o}, o_c, o_h, o_mul_{ai,fc} gates, new cell state, hidden output, products
interface lstm_cell_seq_if #(parameter int WIDTH = 24);
  logic             i_start, i_first;
  logic [WIDTH-1:0] i_b_a, i_b_i, i_b_f, i_b_o;
  logic             i_valid, o_ready;
  logic [WIDTH-1:0] i_d, i_w_a, i_w_i, i_w_f, i_w_o;
  logic             o_valid, i_ready;
  logic [WIDTH-1:0] o_a, o_i, o_f, o_o, o_c, o_h, o_mul_ai, o_mul_fc;

  modport slave (
    input  i_start, i_first, i_b_a, i_b_i, i_b_f, i_b_o,
    input  i_valid, i_d, i_w_a, i_w_i, i_w_f, i_w_o, i_ready,
    output o_ready, o_valid,
    output o_a, o_i, o_f, o_o, o_c, o_h, o_mul_ai, o_mul_fc
  );

  modport master (
    output i_start, i_first, i_b_a, i_b_i, i_b_f, i_b_o,
    output i_valid, i_d, i_w_a, i_w_i, i_w_f, i_w_o, i_ready,
    input  o_ready, o_valid,
    input  o_a, o_i, o_f, o_o, o_c, o_h, o_mul_ai, o_mul_fc
  );
endinterface

// File: rtl/lstm_cell_seq.sv
// lstm_cell_seq: one timestep of one LSTM hidden unit.
// A serial stream of NX x elements then NH h elements is multiply-accumulated
// into four gate pre-activations (a, i, f, o). The gates are activated and
// registered, then the cell update runs:
//   c = a*i + f*c(t-1),  h = o*tanh(c).
// c(t-1) lives in an internal register across timesteps.
// Ports: clk, rst (synchronous, active-high), bus (lstm_cell_seq_if.slave).
// Activations are piecewise-linear:
//   tanh(x)    = clamp(x, -1, 1)
//   sigmoid(x) = clamp(0.5 + x/4, 0, 1)
// Optional macro LSTM_SAT_EN: the accumulator->WIDTH reduction and the c
// addition saturate. When it is undefined, both wrap (two's complement).

// Combinational activation unit (hard tanh or hard sigmoid).
module lstm_act #(
  parameter int WIDTH   = 24,
  parameter int FRAC    = 20,
  parameter bit IS_TANH = 1'b0
) (
  input  logic signed [WIDTH-1:0] pre,
  output logic signed [WIDTH-1:0] act
);
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(longint'(1) << FRAC);
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
  localparam logic signed [WIDTH:0]   ONE_X   = (WIDTH+1)'(ONE);
  localparam logic signed [WIDTH:0]   HALF_X  = ONE_X >>> 1;

  // One extra bit so that 0.5 + x/4 cannot overflow before the clamp.
  logic signed [WIDTH:0] sig_x;

  always_comb begin
    act   = '0;
    sig_x = (WIDTH+1)'(pre >>> 2) + HALF_X;
    if (IS_TANH) begin
      if (pre > ONE)          act = ONE;
      else if (pre < NEG_ONE) act = NEG_ONE;
      else                    act = pre;
    end else begin
      if (sig_x > ONE_X)   act = ONE;
      else if (sig_x[WIDTH]) act = '0;
      else                 act = sig_x[WIDTH-1:0];
    end
  end
endmodule

// One gate lane: accumulator, reduction to WIDTH, activation, gate register.
module lstm_gate_lane #(
  parameter int WIDTH   = 24,
  parameter int FRAC    = 20,
  parameter int GUARD   = 4,
  parameter bit IS_TANH = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    acc_en,
  input  logic                    act_en,
  input  logic signed [WIDTH-1:0] bias,
  input  logic signed [WIDTH-1:0] d,
  input  logic signed [WIDTH-1:0] w,
  output logic signed [WIDTH-1:0] gate_q
);
  localparam int AW = WIDTH + GUARD;

  logic signed [AW-1:0]      acc_q, acc_d;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   pre, act, gate_d;

  always_comb begin
    prod  = (2*WIDTH)'(d) * (2*WIDTH)'(w);
    acc_d = acc_q;
    if (load)        acc_d = AW'(bias);
    else if (acc_en) acc_d = acc_q + AW'(prod >>> FRAC);
  end

`ifdef LSTM_SAT_EN
  localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};
  always_comb begin
    if (acc_q > AW'(MAXW))      pre = MAXW;
    else if (acc_q < AW'(MINW)) pre = MINW;
    else                        pre = acc_q[WIDTH-1:0];
  end
`else
  assign pre = acc_q[WIDTH-1:0];
`endif

  lstm_act #(.WIDTH(WIDTH), .FRAC(FRAC), .IS_TANH(IS_TANH)) u_act (.pre(pre), .act(act));

  assign gate_d = act_en ? act : gate_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      gate_q <= '0;
    end else begin
      acc_q  <= acc_d;
      gate_q <= gate_d;
    end
  end
endmodule

module lstm_cell_seq #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 20,
  parameter int NX    = 4,
  parameter int NH    = 4,
  parameter int GUARD = 4
) (
  input logic           clk,
  input logic           rst,
  lstm_cell_seq_if.slave bus
);
  localparam int NMAX = (NX > NH) ? NX : NH;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ACC_X, S_ACC_H, S_ACT, S_CELL, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] c_reg_q, c_reg_d, c_q, c_d, h_q, h_d;
  logic signed [WIDTH-1:0] mul_ai_q, mul_ai_d, mul_fc_q, mul_fc_d;
  logic                    load, acc_en, act_en;

  // Lane order: 0=a, 1=i, 2=f, 3=o.
  logic [3:0][WIDTH-1:0]     bias_vec, w_vec, gate_vec;
  logic signed [WIDTH-1:0]   ga, gi, gf, go, ai_w, fc_w, c_new, tanh_c, h_w;
  logic signed [2*WIDTH-1:0] p_ai, p_fc, p_h;

  assign bias_vec = {bus.i_b_o, bus.i_b_f, bus.i_b_i, bus.i_b_a};
  assign w_vec    = {bus.i_w_o, bus.i_w_f, bus.i_w_i, bus.i_w_a};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    lstm_gate_lane #(
      .WIDTH(WIDTH), .FRAC(FRAC), .GUARD(GUARD), .IS_TANH(g == 0)
    ) u_lane (
      .clk(clk), .rst(rst), .load(load), .acc_en(acc_en), .act_en(act_en),
      .bias(bias_vec[g]), .d(bus.i_d), .w(w_vec[g]), .gate_q(gate_vec[g])
    );
  end

  assign ga = $signed(gate_vec[0]);
  assign gi = $signed(gate_vec[1]);
  assign gf = $signed(gate_vec[2]);
  assign go = $signed(gate_vec[3]);

  // Cell datapath; only consumed in CELL, when the gate registers are settled.
`ifdef LSTM_SAT_EN
  localparam logic signed [WIDTH-1:0] MAXW = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW = {1'b1, {(WIDTH-1){1'b0}}};
  logic signed [WIDTH:0] c_sum;
`endif

  always_comb begin
    p_ai = (2*WIDTH)'(ga) * (2*WIDTH)'(gi);
    p_fc = (2*WIDTH)'(gf) * (2*WIDTH)'(c_reg_q);
    ai_w = WIDTH'(p_ai >>> FRAC);
    fc_w = WIDTH'(p_fc >>> FRAC);
`ifdef LSTM_SAT_EN
    c_sum = (WIDTH+1)'(ai_w) + (WIDTH+1)'(fc_w);
    if (c_sum > (WIDTH+1)'(MAXW))      c_new = MAXW;
    else if (c_sum < (WIDTH+1)'(MINW)) c_new = MINW;
    else                               c_new = c_sum[WIDTH-1:0];
`else
    c_new = ai_w + fc_w;
`endif
  end

  lstm_act #(.WIDTH(WIDTH), .FRAC(FRAC), .IS_TANH(1'b1)) u_tanh_c (.pre(c_new), .act(tanh_c));

  always_comb begin
    p_h = (2*WIDTH)'(go) * (2*WIDTH)'(tanh_c);
    h_w = WIDTH'(p_h >>> FRAC);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    c_reg_d  = c_reg_q;
    c_d      = c_q;
    h_d      = h_q;
    mul_ai_d = mul_ai_q;
    mul_fc_d = mul_fc_q;
    load     = 1'b0;
    acc_en   = 1'b0;
    act_en   = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.i_start) begin
        load  = 1'b1;
        cnt_d = '0;
        if (bus.i_first) c_reg_d = '0;
        state_d = S_ACC_X;
      end
      S_ACC_X: if (bus.i_valid) begin
        acc_en = 1'b1;
        if (cnt_q == CW'(NX - 1)) begin
          cnt_d   = '0;
          state_d = S_ACC_H;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACC_H: if (bus.i_valid) begin
        acc_en = 1'b1;
        if (cnt_q == CW'(NH - 1)) begin
          cnt_d   = '0;
          state_d = S_ACT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACT: begin
        act_en  = 1'b1;
        state_d = S_CELL;
      end
      S_CELL: begin
        c_d      = c_new;
        h_d      = h_w;
        mul_ai_d = ai_w;
        mul_fc_d = fc_w;
        c_reg_d  = c_new;
        state_d  = S_DONE;
      end
      // i_start is deliberately not looked at here, even alongside i_ready.
      S_DONE:  if (bus.i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      c_reg_q  <= '0;
      c_q      <= '0;
      h_q      <= '0;
      mul_ai_q <= '0;
      mul_fc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      c_reg_q  <= c_reg_d;
      c_q      <= c_d;
      h_q      <= h_d;
      mul_ai_q <= mul_ai_d;
      mul_fc_q <= mul_fc_d;
    end
  end

  assign bus.o_ready  = (state_q == S_ACC_X) || (state_q == S_ACC_H);
  assign bus.o_valid  = (state_q == S_DONE);
  assign bus.o_a      = gate_vec[0];
  assign bus.o_i      = gate_vec[1];
  assign bus.o_f      = gate_vec[2];
  assign bus.o_o      = gate_vec[3];
  assign bus.o_c      = c_q;
  assign bus.o_h      = h_q;
  assign bus.o_mul_ai = mul_ai_q;
  assign bus.o_mul_fc = mul_fc_q;
endmodule

// File: doc/lstm_cell_seq.md
# lstm_cell_seq

Sequenced, parametrised LSTM cell that computes one timestep of one hidden unit from a serial stream of NX input elements and NH recurrent elements. It accumulates the four gate pre-activations (a, i, f, o) with an internal FSM instead of external acc_x/acc_h strobes, and keeps c(t-1) in an internal state register across timesteps. Gate values and products are exposed for the backpropagation datapath. It sits inside an LSTM layer, one instance per hidden unit, fed by the layer's weight/activation sequencer.

## Interface
- WIDTH, 24, signed fixed-point word width
- FRAC, 20, fractional bits (1.0 = 2^FRAC)
- NX, 4, input-vector elements per timestep (≥1)
- NH, 4, recurrent h elements per timestep (≥1)
- GUARD, 4, extra accumulator integer bits

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  starts a timestep; honoured only in IDLE
- i_first  in  1  sampled with i_start; 1 = new sequence, c(t-1) treated as 0
- i_b_a, i_b_i, i_b_f, i_b_o  in  WIDTH each  biases, sampled with i_start
- i_valid  in  1  stream element valid
- o_ready  out  1  block accepts stream element
- i_d  in  WIDTH  stream element: x elements first, then h elements
- i_w_a, i_w_i, i_w_f, i_w_o  in  WIDTH each  weight paired with i_d (W during x phase, U during h phase)
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_a, o_i, o_f, o_o  out  WIDTH each  registered gate activations
- o_c, o_h  out  WIDTH each  registered new cell state, hidden output
- o_mul_ai, o_mul_fc  out  WIDTH each  registered a·i and f·c(t-1)

## Operation
- States: IDLE → ACC_X → ACC_H → ACT → CELL → DONE → IDLE.
- IDLE: o_ready=0. On i_start: each gate accumulator ← sign-extended bias; if i_first, c_reg ← 0; element counter ← 0; go ACC_X.
- ACC_X / ACC_H: o_ready=1. On i_valid&&o_ready, each accumulator += (i_d·i_w_g)>>>FRAC (full 2·WIDTH product, arithmetic shift, truncation). Counter wraps to 0 and state advances after the NX-th (ACC_X) or NH-th (ACC_H) accepted element. Cycles with i_valid=0 are stalls, no change.
- ACT: o_ready=0. Each accumulator reduced to WIDTH (see Configuration); a ← tanh, i/f/o ← sigmoid via the codebase's combinational `tanh`/`sigmoid` units; gates registered.
- CELL: mul_ai = a·i, mul_fc = f·c_reg (same product rule); c_new = mul_ai + mul_fc; h = o·tanh(c_new); o_c, o_h, o_mul_* registered; c_reg ← c_new.
- DONE: o_valid=1, outputs held stable; on i_ready go IDLE. i_start in DONE is ignored, including when i_ready is high the same cycle.
- i_start outside IDLE ignored; i_first without i_start ignored.
- rst (any state, including mid-stream): state ← IDLE, counter, accumulators, c_reg and all outputs ← 0, o_ready=0, o_valid=0.

## Timing
- Last element accepted at edge k: ACT during cycle k→k+1, gates registered at k+1, CELL results registered at k+2, o_valid high from k+2.
- Minimum timestep: 1 (start) + NX + NH + 2 cycles to o_valid; +1 handshake cycle before next i_start.
- o_valid is registered and never depends combinationally on i_ready; o_ready depends only on state.
- All outputs change only at the CELL→DONE edge (o_a..o_o at ACT→CELL) and reset.

## Configuration
- LSTM_SAT_EN defined: accumulator→WIDTH reduction and c_new addition saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Not defined: both wrap (two's-complement truncation to WIDTH bits); no saturation logic present.

## Test plan
- NX=2, NH=1, all weights and biases 0, i_first=1 → o_a=0, o_i=o_f=o_o=0x080000, o_c=0, o_h=0; o_valid exactly 5 cycles after i_start.
- Weights 0, i_b_a=i_b_i=0x7FFFFF-scale (a≈1, i≈1), i_first=1, then second step with i_first=0, f bias large → o_c of step 2 ≈ step-1 c plus a·i; c_reg carried, not reset.
- Random i_valid gaps (50% duty) during ACC_X/ACC_H → results bit-identical to gapless run; o_ready low outside ACC states.
- Hold i_ready=0 for 10 cycles in DONE with i_start pulsed → outputs stable, i_start ignored, no new timestep.
- Accumulate NX=4 products of 0x700000·0x700000 with LSTM_SAT_EN → pre-activation clamps to 0x7FFFFF; without macro → wrapped value observed at activation input.
- Assert rst during ACC_H after 1 element → next cycle state IDLE, all outputs 0, o_valid=0; subsequent i_start with i_first=0 uses c(t-1)=0.
